// File: rtl/da_fir_filter.sv
// Bit-serial distributed-arithmetic FIR filter.
// Holds its own tap delay line and walks the samples LSB-first, one bit per enabled cycle.
// Each cycle it adds a shifted LUT partial sum to the accumulator.
// The sign-bit cycle subtracts that partial sum instead of adding it.
module da_fir_filter #(
  parameter int word_width   = 16,
  parameter int filter_order = 4,
  parameter int coef_width   = 16,
  parameter logic [filter_order*coef_width-1:0] COEFS = {filter_order{16'sd1}}
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   en,
  input  logic                                                   x_valid,
  output logic                                                   x_ready,
  input  logic [word_width-1:0]                                  x,
  output logic [word_width+coef_width+$clog2(filter_order)-1:0]  y,
  output logic                                                   y_valid
);

  localparam int unsigned OUT_W = word_width + coef_width + $clog2(filter_order);
  localparam int unsigned CNT_W = (word_width > 1) ? $clog2(word_width) : 1;
  localparam int unsigned LUT_N = 2 ** filter_order;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(word_width - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [word_width-1:0]   dly_q [filter_order];
  logic [word_width-1:0]   dly_d [filter_order];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        acc_q, acc_d;
  logic [OUT_W-1:0]        y_q, y_d;
  logic                    y_valid_q, y_valid_d;
  logic [filter_order-1:0] addr;
  logic [OUT_W-1:0]        term;
  logic [OUT_W-1:0]        lut [LUT_N];

  // Sum of the coefficients selected by the address bits, sign-extended to OUT_W
  function automatic logic [OUT_W-1:0] lut_entry(input logic [filter_order-1:0] a);
    logic [OUT_W-1:0]      s;
    logic [coef_width-1:0] c;
    s = '0;
    for (int unsigned k = 0; k < filter_order; k++) begin
      c = COEFS[k*coef_width +: coef_width];
      if (a[k]) s = s + {{(OUT_W-coef_width){c[coef_width-1]}}, c};
    end
    return s;
  endfunction

  // Every LUT entry depends on constants only, so the table folds at elaboration
  for (genvar a = 0; a < LUT_N; a++) begin : g_lut
    localparam logic [filter_order-1:0] ADDR = a;
    assign lut[a] = lut_entry(ADDR);
  end

  // LUT address is the current bit slice across all taps; the partial sum is weighted by 2**b
  always_comb begin
    addr = '0;
    for (int unsigned k = 0; k < filter_order; k++) addr[k] = dly_q[k][cnt_q];
    term = lut[addr] << cnt_q;
  end

  assign x_ready = (state_q == IDLE) && en;
  assign y       = y_q;
  assign y_valid = y_valid_q;

  // Next-state logic: accept into the delay line, then shift/accumulate until the sign bit
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (x_valid) begin
            dly_d[0] = x;
            for (int unsigned k = 1; k < filter_order; k++) dly_d[k] = dly_q[k-1];
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
        RUN: begin
          if (cnt_q == LAST_BIT) begin
            acc_d     = acc_q - term;
            y_d       = acc_d;
            y_valid_d = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            acc_d = acc_q + term;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over enable and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int unsigned k = 0; k < filter_order; k++) dly_q[k] <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

endmodule

// File: tb/tb_da_fir_filter.sv
// Directed bench for da_fir_filter: 8-bit samples, 4 taps, 8-bit coefficients.
module tb_da_fir_filter;

  localparam int WW = 8;
  localparam int FO = 4;
  localparam int CW = 8;
  localparam int OW = WW + CW + $clog2(FO);

  logic          clk = 1'b0;
  logic          rst, en;
  logic          x_valid, x_valid2;
  logic [WW-1:0] x, x2;
  logic          x_ready, x_ready2;
  logic [OW-1:0] y, y2;
  logic          y_valid, y_valid2;

  int errors  = 0;
  int checks  = 0;
  int accepts = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  da_fir_filter #(
    .word_width  (WW),
    .filter_order(FO),
    .coef_width  (CW),
    .COEFS       (32'h04_03_02_01)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x      (x),
    .y      (y),
    .y_valid(y_valid)
  );

  da_fir_filter #(
    .word_width  (WW),
    .filter_order(FO),
    .coef_width  (CW),
    .COEFS       (32'h80_80_80_80)
  ) dut_neg (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .x_valid(x_valid2),
    .x_ready(x_ready2),
    .x      (x2),
    .y      (y2),
    .y_valid(y_valid2)
  );

  // Handshakes are counted just before the edge that would take them
  always @(negedge clk) if (x_valid && x_ready) accepts++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b1;
    x_valid  = 1'b0;
    x_valid2 = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_pulse(input bit sel, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(sel ? y_valid2 : y_valid) && cyc < 40);
  endtask

  task automatic accept1(input logic [WW-1:0] v);
    x       = v;
    x_valid = 1'b1;
    check("x_ready_idle", x_ready, 1);
    step();
    x_valid = 1'b0;
  endtask

  logic [WW-1:0] imp_x [5] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
  int            imp_y [5] = '{1, 2, 3, 4, 0};
  logic [WW-1:0] sgn_x [5] = '{8'h80, 8'd0, 8'd0, 8'd0, 8'd0};
  int            sgn_y [5] = '{-128, -256, -384, -512, 0};
  int            fs_y  [5] = '{127, 381, 762, 1270, 1270};
  int            neg_y [5] = '{16384, 32768, 49152, 65536, 65536};

  initial begin
    x  = '0;
    x2 = '0;
    do_reset();
    check("rst_y", $signed(y), 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_x_ready", x_ready, 1);
    check("rst_y_neg", $signed(y2), 0);

    // Impulse through the delay line
    for (int i = 0; i < 5; i++) begin
      accept1(imp_x[i]);
      wait_pulse(1'b0, n);
      check("imp_latency", n, 8);
      check("imp_y", $signed(y), imp_y[i]);
    end
    step();
    check("imp_pulse_width", y_valid, 0);
    check("imp_y_hold", $signed(y), 0);

    // Sign-bit subtraction
    do_reset();
    for (int i = 0; i < 5; i++) begin
      accept1(sgn_x[i]);
      wait_pulse(1'b0, n);
      check("sgn_y", $signed(y), sgn_y[i]);
    end

    // Full-scale positive stream, back-to-back
    do_reset();
    x       = 8'd127;
    x_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      wait_pulse(1'b0, n);
      check("fs_spacing", n, (i == 0) ? 8 : 9);
      check("fs_y", $signed(y), fs_y[i]);
      check("fs_ready_in_valid", x_ready, 1);
    end
    x_valid = 1'b0;

    // Full-scale negative coefficients and samples
    do_reset();
    x2       = 8'h80;
    x_valid2 = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      wait_pulse(1'b1, n);
      check("neg_spacing", n, (i == 0) ? 8 : 9);
      check("neg_y", $signed(y2), neg_y[i]);
    end
    x_valid2 = 1'b0;

    // Enable stall mid-RUN
    do_reset();
    accept1(8'd1);
    repeat (3) step();
    en      = 1'b0;
    x       = 8'd7;
    x_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("stall_x_ready", x_ready, 0);
      step();
      check("stall_no_valid", y_valid, 0);
    end
    en      = 1'b1;
    x_valid = 1'b0;
    wait_pulse(1'b0, n);
    check("stall_remaining", n, 5);
    check("stall_y", $signed(y), 1);
    en = 1'b0;
    step();
    check("y_valid_clears_en0", y_valid, 0);
    check("y_hold_en0", $signed(y), 1);
    en = 1'b1;

    // Reset during RUN aborts the sample
    do_reset();
    accept1(8'd3);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_y_valid", y_valid, 0);
    check("abort_y", $signed(y), 0);
    check("abort_x_ready", x_ready, 1);
    pulses = 0;
    repeat (12) begin
      step();
      if (y_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    accept1(8'd1);
    wait_pulse(1'b0, n);
    check("abort_next_latency", n, 8);
    check("abort_next_y", $signed(y), 1);

    // Source holds a sample while the filter is busy
    do_reset();
    accepts = 0;
    x       = 8'd1;
    x_valid = 1'b1;
    step();
    x = 8'd5;
    wait_pulse(1'b0, n);
    check("busy_latency", n, 8);
    check("busy_y0", $signed(y), 1);
    check("busy_ready_in_valid", x_ready, 1);
    wait_pulse(1'b0, n);
    check("busy_spacing", n, 9);
    check("busy_y1", $signed(y), 7);
    check("busy_accepts", accepts, 2);
    x_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
